// File: rtl/bcd_pkg.sv
// Shared BCD digit limits for the two-decade counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade: loadable up/down counter with a decade carry/borrow.
// Latency: q updates one cycle after load/en; carry is combinational.
// Backpressure: none; en=0 holds the digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d,
  input  logic [3:0] wrap_val,
  output logic [3:0] q,
  output logic       carry
);

  // Carry on up means 9->0 next edge; on down it flags the 0->wrap_val borrow.
  assign carry = en & (up ? (q == BCD_MAX) : (q == BCD_MIN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      if (up) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      else    q <= (q == BCD_MIN) ? wrap_val : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter2.sv
// Two-digit BCD up/down counter, modulus MODULO, with validated parallel load.
// Latency: count and load_err update one cycle after inputs; tc is combinational.
// Backpressure: none; en=0 and load=0 holds the count.
module bcd_counter2
  import bcd_pkg::*;
#(
  parameter int MODULO = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d_tens,
  input  logic [3:0] d_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tc,
  output logic       load_err
);

  localparam logic [3:0] MAX_T = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MODULO - 1) % 10);
  localparam logic [7:0] MOD8  = 8'(MODULO);

  logic [7:0] load_val;
  logic       load_ok;
  logic       cnt_en;
  logic       at_max;
  logic       wrap;
  logic       digit_load;
  logic       ones_carry;
  logic       tens_carry;
  logic [3:0] d_o;
  logic [3:0] d_t;

  assign load_val = {4'd0, d_tens} * 8'd10 + {4'd0, d_ones};
  assign load_ok  = (d_tens <= BCD_MAX) && (d_ones <= BCD_MAX) && (load_val < MOD8);

  // Any load request, legal or not, blocks counting for that cycle.
  assign cnt_en = en & ~load;
  assign at_max = (tens == MAX_T) && (ones == MAX_O);

  // Down wrap is exactly a borrow out of the tens digit; up wrap must honour MODULO.
  assign wrap = up ? (cnt_en & at_max) : tens_carry;

  // The modulus wrap reuses the digits' load path so it overrides their own counting.
  assign digit_load = (load & load_ok) | wrap;
  assign d_o = load ? d_ones : (up ? BCD_MIN : MAX_O);
  assign d_t = load ? d_tens : (up ? BCD_MIN : MAX_T);

  assign tc = rst_n & wrap;

  bcd_digit u_ones (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .up       (up),
    .load     (digit_load),
    .d        (d_o),
    .wrap_val (BCD_MAX),
    .q        (ones),
    .carry    (ones_carry)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ones_carry),
    .up       (up),
    .load     (digit_load),
    .d        (d_t),
    .wrap_val (BCD_MAX),
    .q        (tens),
    .carry    (tens_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) load_err <= 1'b0;
    else        load_err <= load & ~load_ok;
  end

endmodule

// File: tb/tb_bcd_counter2.sv
// Directed bench for bcd_counter2 at MODULO=100 (instance a) and MODULO=60 (instance b).
module tb_bcd_counter2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, en_a, up_a, load_a, tc_a, err_a;
  logic [3:0] dt_a, do_a, tens_a, ones_a;
  logic       rst_n_b, en_b, up_b, load_b, tc_b, err_b;
  logic [3:0] dt_b, do_b, tens_b, ones_b;

  int checks   = 0;
  int failures = 0;

  bcd_counter2 #(.MODULO(100)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .up(up_a), .load(load_a),
    .d_tens(dt_a), .d_ones(do_a), .tens(tens_a), .ones(ones_a),
    .tc(tc_a), .load_err(err_a)
  );

  bcd_counter2 #(.MODULO(60)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .up(up_b), .load(load_b),
    .d_tens(dt_b), .d_ones(do_b), .tens(tens_b), .ones(ones_b),
    .tc(tc_b), .load_err(err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; en_a = 1'b1; up_a = 1'b0; load_a = 1'b1; dt_a = 4'd5; do_a = 4'd5;
    rst_n_b = 1'b0; en_b = 1'b1; up_b = 1'b0; load_b = 1'b1; dt_b = 4'd3; do_b = 4'hA;
    tick(); tick();
    checks++; if ({tens_a, ones_a} !== 8'h00) begin failures++; $display("FAIL reset_cnt_a got=%h exp=00", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err_a got=%b exp=0", err_a); end
    checks++; if ({tens_b, ones_b} !== 8'h00) begin failures++; $display("FAIL reset_cnt_b got=%h exp=00", {tens_b, ones_b}); end
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL reset_err_b got=%b exp=0", err_b); end
    load_a = 1'b0; load_b = 1'b0;
    #1;
    checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL reset_tc_a got=%b exp=0", tc_a); end
    checks++; if (tc_b !== 1'b0) begin failures++; $display("FAIL reset_tc_b got=%b exp=0", tc_b); end
  endtask

  task automatic test_up_count();
    logic [7:0] exp;
    rst_n_a = 1'b1; en_a = 1'b1; up_a = 1'b1; load_a = 1'b0;
    #1;
    for (int i = 1; i <= 10; i++) begin
      checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL up_tc step=%0d got=%b exp=0", i, tc_a); end
      tick();
      exp = {4'(i / 10), 4'(i % 10)};
      checks++; if ({tens_a, ones_a} !== exp) begin failures++; $display("FAIL up_cnt step=%0d got=%h exp=%h", i, {tens_a, ones_a}, exp); end
    end
  endtask

  task automatic test_hold();
    en_a = 1'b0;
    tick(); tick(); tick();
    checks++; if ({tens_a, ones_a} !== 8'h10) begin failures++; $display("FAIL hold_cnt got=%h exp=10", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL hold_err got=%b exp=0", err_a); end
    checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL hold_tc got=%b exp=0", tc_a); end
  endtask

  task automatic test_up_wrap();
    load_a = 1'b1; dt_a = 4'd9; do_a = 4'd9; en_a = 1'b0;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h99) begin failures++; $display("FAIL load99_cnt got=%h exp=99", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL load99_err got=%b exp=0", err_a); end
    load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    #1;
    checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL upwrap_tc99 got=%b exp=1", tc_a); end
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h00) begin failures++; $display("FAIL upwrap_cnt got=%h exp=00", {tens_a, ones_a}); end
    checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL upwrap_tc00 got=%b exp=0", tc_a); end
  endtask

  task automatic test_down_and_direction();
    up_a = 1'b0; en_a = 1'b1;
    #1;
    checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL dn_tc00 got=%b exp=1", tc_a); end
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h99) begin failures++; $display("FAIL dnwrap_cnt got=%h exp=99", {tens_a, ones_a}); end
    checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL dn_tc99 got=%b exp=0", tc_a); end
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h98) begin failures++; $display("FAIL dn_cnt98 got=%h exp=98", {tens_a, ones_a}); end
    load_a = 1'b1; dt_a = 4'd1; do_a = 4'd0; en_a = 1'b0;
    tick();
    load_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h09) begin failures++; $display("FAIL dn_borrow got=%h exp=09", {tens_a, ones_a}); end
    up_a = 1'b1;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h10) begin failures++; $display("FAIL dir_up got=%h exp=10", {tens_a, ones_a}); end
    up_a = 1'b0;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h09) begin failures++; $display("FAIL dir_dn got=%h exp=09", {tens_a, ones_a}); end
  endtask

  task automatic test_illegal_load();
    load_a = 1'b1; dt_a = 4'd4; do_a = 4'd2; en_a = 1'b0;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h42) begin failures++; $display("FAIL load42_cnt got=%h exp=42", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL load42_err got=%b exp=0", err_a); end
    dt_a = 4'd3; do_a = 4'hA; en_a = 1'b1; up_a = 1'b1;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h42) begin failures++; $display("FAIL badones_cnt got=%h exp=42", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL badones_err got=%b exp=1", err_a); end
    load_a = 1'b0; en_a = 1'b0;
    tick();
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err_a); end
    checks++; if ({tens_a, ones_a} !== 8'h42) begin failures++; $display("FAIL after_bad_cnt got=%h exp=42", {tens_a, ones_a}); end
    load_a = 1'b1; dt_a = 4'hA; do_a = 4'd0;
    tick();
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL badtens_err got=%b exp=1", err_a); end
    checks++; if ({tens_a, ones_a} !== 8'h42) begin failures++; $display("FAIL badtens_cnt got=%h exp=42", {tens_a, ones_a}); end
  endtask

  task automatic test_simultaneous();
    load_a = 1'b1; dt_a = 4'd2; do_a = 4'd5; en_a = 1'b1; up_a = 1'b1;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h25) begin failures++; $display("FAIL load_vs_en got=%h exp=25", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL load_vs_en_err got=%b exp=0", err_a); end
    dt_a = 4'd3; do_a = 4'd7; en_a = 1'b0;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h37) begin failures++; $display("FAIL load37 got=%h exp=37", {tens_a, ones_a}); end
    rst_n_a = 1'b0; load_a = 1'b1; dt_a = 4'd3; do_a = 4'hA; en_a = 1'b1;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h00) begin failures++; $display("FAIL rst_vs_load got=%h exp=00", {tens_a, ones_a}); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_vs_load_err got=%b exp=0", err_a); end
    rst_n_a = 1'b1; load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    tick();
    checks++; if ({tens_a, ones_a} !== 8'h01) begin failures++; $display("FAIL resume got=%h exp=01", {tens_a, ones_a}); end
  endtask

  task automatic test_mod60();
    rst_n_b = 1'b1; load_b = 1'b0; en_b = 1'b1; up_b = 1'b0;
    #1;
    checks++; if (tc_b !== 1'b1) begin failures++; $display("FAIL m60_dn_tc got=%b exp=1", tc_b); end
    tick();
    checks++; if ({tens_b, ones_b} !== 8'h59) begin failures++; $display("FAIL m60_dnwrap got=%h exp=59", {tens_b, ones_b}); end
    checks++; if (tc_b !== 1'b0) begin failures++; $display("FAIL m60_dn_tc59 got=%b exp=0", tc_b); end
    up_b = 1'b1;
    #1;
    checks++; if (tc_b !== 1'b1) begin failures++; $display("FAIL m60_up_tc got=%b exp=1", tc_b); end
    tick();
    checks++; if ({tens_b, ones_b} !== 8'h00) begin failures++; $display("FAIL m60_upwrap got=%h exp=00", {tens_b, ones_b}); end
    load_b = 1'b1; dt_b = 4'd4; do_b = 4'd9; en_b = 1'b0;
    tick();
    load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    tick();
    checks++; if ({tens_b, ones_b} !== 8'h50) begin failures++; $display("FAIL m60_carry got=%h exp=50", {tens_b, ones_b}); end
    load_b = 1'b1; dt_b = 4'd2; do_b = 4'd3; en_b = 1'b0;
    tick();
    dt_b = 4'd7; do_b = 4'd0;
    tick();
    checks++; if ({tens_b, ones_b} !== 8'h23) begin failures++; $display("FAIL m60_load70_cnt got=%h exp=23", {tens_b, ones_b}); end
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL m60_load70_err got=%b exp=1", err_b); end
    dt_b = 4'd6; do_b = 4'd0;
    tick();
    checks++; if ({tens_b, ones_b} !== 8'h23) begin failures++; $display("FAIL m60_load60_cnt got=%h exp=23", {tens_b, ones_b}); end
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL m60_load60_err got=%b exp=1", err_b); end
    dt_b = 4'd5; do_b = 4'd9;
    tick();
    checks++; if ({tens_b, ones_b} !== 8'h59) begin failures++; $display("FAIL m60_load59_cnt got=%h exp=59", {tens_b, ones_b}); end
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL m60_load59_err got=%b exp=0", err_b); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_hold();
    test_up_wrap();
    test_down_and_direction();
    test_illegal_load();
    test_simultaneous();
    test_mod60();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
